// File: rtl/dds_sweep_ctrl.sv
// DDS frequency-sweep scheduler: steps the tuning word from start to stop with a per-word dwell.
// Optional phase-aligned stepping (wait for acc_wrap before each load) is enabled by PHASE_ALIGN_EN.
module dds_sweep_ctrl #(
    parameter int FTW_W   = 32,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               abort,
    input  logic [FTW_W-1:0]   start_ftw,
    input  logic [FTW_W-1:0]   stop_ftw,
    input  logic [FTW_W-1:0]   step_ftw,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [1:0]         mode,
    input  logic               acc_wrap,
    output logic [FTW_W-1:0]   ftw,
    output logic               ftw_load,
    output logic               busy,
    output logic               done,
    output logic               err
);

`ifdef PHASE_ALIGN_EN
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_HOLD      = 2'd1,
        S_WAIT_WRAP = 2'd2,
        S_FINISH    = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_FINISH = 2'd3
    } state_t;
`endif

    localparam logic [DWELL_W-1:0] CNT_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};
    localparam logic [DWELL_W-1:0] CNT_ZERO = {DWELL_W{1'b0}};
    localparam logic [FTW_W-1:0]   FTW_ZERO = {FTW_W{1'b0}};

    // One step toward tgt, computed one bit wider so carry/borrow past the range clamps to tgt.
    function automatic logic [FTW_W-1:0] clamp_step(
        input logic [FTW_W-1:0] cur,
        input logic [FTW_W-1:0] stp,
        input logic [FTW_W-1:0] tgt,
        input logic             up
    );
        logic [FTW_W:0] res;
        if (up) begin
            res = {1'b0, cur} + {1'b0, stp};
            if (res[FTW_W] || (res[FTW_W-1:0] >= tgt)) clamp_step = tgt;
            else                                       clamp_step = res[FTW_W-1:0];
        end else begin
            res = {1'b0, cur} - {1'b0, stp};
            if (res[FTW_W] || (res[FTW_W-1:0] <= tgt)) clamp_step = tgt;
            else                                       clamp_step = res[FTW_W-1:0];
        end
    endfunction

    state_t             r_state,  w_state_n;
    logic [FTW_W-1:0]   r_ftw,    w_ftw_n;
    logic               r_ftw_load, w_ftw_load_n;
    logic               r_busy,   w_busy_n;
    logic               r_done,   w_done_n;
    logic               r_err,    w_err_n;
    logic [DWELL_W-1:0] r_cnt,    w_cnt_n;
    logic [FTW_W-1:0]   r_start,  w_start_n;
    logic [FTW_W-1:0]   r_stop,   w_stop_n;
    logic [FTW_W-1:0]   r_step,   w_step_n;
    logic [DWELL_W-1:0] r_dwell,  w_dwell_n;
    logic [1:0]         r_mode,   w_mode_n;
    logic               r_up,     w_up_n;

    logic w_expire;
    logic w_at_end;
    logic w_reject;
    logic w_do_adv;

    assign w_expire = (r_cnt >= r_dwell);
    assign w_at_end = (r_ftw == r_stop);
    assign w_reject = (mode == 2'd3) || ((step_ftw == FTW_ZERO) && (start_ftw != stop_ftw));

`ifndef PHASE_ALIGN_EN
    logic w_unused_acc_wrap;
    assign w_unused_acc_wrap = acc_wrap;
`endif

    // Decide whether the current word's hold is over and the next action should happen now.
    always_comb begin
        w_do_adv = 1'b0;
        case (r_state)
`ifdef PHASE_ALIGN_EN
            S_HOLD:      w_do_adv = w_expire & acc_wrap;
            S_WAIT_WRAP: w_do_adv = acc_wrap;
`else
            S_HOLD:      w_do_adv = w_expire;
`endif
            default:     w_do_adv = 1'b0;
        endcase
    end

    // Next-state and next-output logic; all outputs are registered from these values.
    always_comb begin
        w_state_n    = r_state;
        w_ftw_n      = r_ftw;
        w_ftw_load_n = 1'b0;
        w_busy_n     = r_busy;
        w_done_n     = 1'b0;
        w_err_n      = 1'b0;
        w_cnt_n      = r_cnt;
        w_start_n    = r_start;
        w_stop_n     = r_stop;
        w_step_n     = r_step;
        w_dwell_n    = r_dwell;
        w_mode_n     = r_mode;
        w_up_n       = r_up;

        if (abort) begin
            w_state_n = S_IDLE;
            w_busy_n  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && w_reject) begin
                        w_done_n = 1'b1;
                        w_err_n  = 1'b1;
                    end else if (start) begin
                        w_start_n    = start_ftw;
                        w_stop_n     = stop_ftw;
                        w_step_n     = step_ftw;
                        w_dwell_n    = (dwell == CNT_ZERO) ? CNT_ONE : dwell;
                        w_mode_n     = mode;
                        w_up_n       = (stop_ftw >= start_ftw);
                        w_ftw_n      = start_ftw;
                        w_ftw_load_n = 1'b1;
                        w_busy_n     = 1'b1;
                        w_cnt_n      = CNT_ONE;
                        w_state_n    = S_HOLD;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end
`ifdef PHASE_ALIGN_EN
                S_HOLD, S_WAIT_WRAP: begin
`else
                S_HOLD: begin
`endif
                    if (w_do_adv && !w_at_end) begin
                        w_ftw_n      = clamp_step(r_ftw, r_step, r_stop, r_up);
                        w_ftw_load_n = 1'b1;
                        w_cnt_n      = CNT_ONE;
                        w_state_n    = S_HOLD;
                    end else if (w_do_adv) begin
                        // Endpoint: repeat and bounce only reload when the range is non-degenerate.
                        w_cnt_n   = CNT_ONE;
                        w_state_n = S_HOLD;
                        case (r_mode)
                            2'd1: begin
                                if (r_start != r_stop) begin
                                    w_ftw_n      = r_start;
                                    w_ftw_load_n = 1'b1;
                                end else begin
                                    w_ftw_n = r_ftw;
                                end
                            end
                            2'd2: begin
                                w_start_n = r_stop;
                                w_stop_n  = r_start;
                                w_up_n    = ~r_up;
                                if (r_start != r_stop) begin
                                    w_ftw_n      = clamp_step(r_ftw, r_step, r_start, ~r_up);
                                    w_ftw_load_n = 1'b1;
                                end else begin
                                    w_ftw_n = r_ftw;
                                end
                            end
                            default: begin
                                w_state_n = S_FINISH;
                                w_done_n  = 1'b1;
                                w_busy_n  = 1'b0;
                            end
                        endcase
`ifdef PHASE_ALIGN_EN
                    end else if (w_expire) begin
                        w_state_n = S_WAIT_WRAP;
`endif
                    end else begin
                        w_cnt_n = r_cnt + CNT_ONE;
                    end
                end
                S_FINISH: w_state_n = S_IDLE;
                default:  w_state_n = S_IDLE;
            endcase
        end
    end

    // State, configuration and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_ftw      <= FTW_ZERO;
            r_ftw_load <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= CNT_ZERO;
            r_start    <= FTW_ZERO;
            r_stop     <= FTW_ZERO;
            r_step     <= FTW_ZERO;
            r_dwell    <= CNT_ONE;
            r_mode     <= 2'd0;
            r_up       <= 1'b1;
        end else begin
            r_state    <= w_state_n;
            r_ftw      <= w_ftw_n;
            r_ftw_load <= w_ftw_load_n;
            r_busy     <= w_busy_n;
            r_done     <= w_done_n;
            r_err      <= w_err_n;
            r_cnt      <= w_cnt_n;
            r_start    <= w_start_n;
            r_stop     <= w_stop_n;
            r_step     <= w_step_n;
            r_dwell    <= w_dwell_n;
            r_mode     <= w_mode_n;
            r_up       <= w_up_n;
        end
    end

    assign ftw      = r_ftw;
    assign ftw_load = r_ftw_load;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: per-cycle expected outputs are queued with the stimulus
// and compared one entry per clock, sampled 1 time unit after the rising edge.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        abort;
    logic [31:0] start_ftw;
    logic [31:0] stop_ftw;
    logic [31:0] step_ftw;
    logic [15:0] dwell;
    logic [1:0]  mode;
    logic        acc_wrap;
    logic [31:0] ftw;
    logic        ftw_load;
    logic        busy;
    logic        done;
    logic        err;

    typedef struct packed {
        logic [31:0] ftw;
        logic        ld;
        logic        busy;
        logic        done;
        logic        err;
    } obs_t;

    obs_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    dds_sweep_ctrl #(.FTW_W(32), .DWELL_W(16)) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .start_ftw(start_ftw), .stop_ftw(stop_ftw), .step_ftw(step_ftw),
        .dwell(dwell), .mode(mode), .acc_wrap(acc_wrap),
        .ftw(ftw), .ftw_load(ftw_load), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic obs_t cur();
        return {ftw, ftw_load, busy, done, err};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("ftw=%h ld=%b busy=%b done=%b err=%b", o.ftw, o.ld, o.busy, o.done, o.err);
    endfunction

    task automatic push(input logic [31:0] f, input logic l, input logic b, input logic d, input logic e);
        exp_q.push_back({f, l, b, d, e});
    endtask

    task automatic push_word(input logic [31:0] f, input int n);
        push(f, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < n; i++) push(f, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                       input logic [15:0] d, input logic [1:0] m);
        start_ftw = s; stop_ftw = e; step_ftw = st; dwell = d; mode = m; start = 1'b1;
    endtask

    task automatic test_reset();
        obs_t o;
        resetn = 1'b0; start = 1'b0; abort = 1'b0; acc_wrap = 1'b0;
        start_ftw = 32'd0; stop_ftw = 32'd0; step_ftw = 32'd0; dwell = 16'd0; mode = 2'd0;
        #3;
        o = cur(); checks++;
        if (o !== obs_t'(0)) begin errors++; $display("FAIL reset: got %s want all zero", fmt(o)); end
        tick(); tick();
        resetn = 1'b1;
        tick();
        o = cur(); checks++;
        if (o !== obs_t'(0)) begin errors++; $display("FAIL reset_release: got %s want all zero", fmt(o)); end
    endtask

    task automatic test_single_up();
        obs_t e, o;
        cfg(32'd100, 32'd400, 32'd100, 16'd3, 2'd0);
        push_word(32'd100, 3); push_word(32'd200, 3); push_word(32'd300, 3); push_word(32'd400, 3);
        push(32'd400, 1'b0, 1'b0, 1'b1, 1'b0);
        push(32'd400, 1'b0, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            tick(); start = 1'b0;
            e = exp_q.pop_front(); o = cur(); checks++;
            if (o !== e) begin errors++; $display("FAIL single_up: got %s want %s", fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_clamp_down();
        obs_t e, o;
        cfg(32'd1000, 32'd250, 32'd300, 16'd1, 2'd0);
        push_word(32'd1000, 1); push_word(32'd700, 1); push_word(32'd400, 1); push_word(32'd250, 1);
        push(32'd250, 1'b0, 1'b0, 1'b1, 1'b0);
        push(32'd250, 1'b0, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            tick(); start = 1'b0;
            e = exp_q.pop_front(); o = cur(); checks++;
            if (o !== e) begin errors++; $display("FAIL clamp_down: got %s want %s", fmt(o), fmt(e)); end
        end
    endtask

    task automatic test_overflow();
        obs_t e, o;
        int n = 0;
        cfg(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h0000_0200, 16'd1, 2'd0);
        push_word(32'hFFFF_FF00, 1); push_word(32'hFFFF_FFFF, 1);
        push(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        push(32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        push_word(32'd100, 1); push_word(32'd0, 1);
        push(32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        push(32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            if (n == 4) cfg(32'd100, 32'd0, 32'd300, 16'd1, 2'd0);
            tick(); start = 1'b0;
            e = exp_q.pop_front(); o = cur(); checks++;
            if (o !== e) begin errors++; $display("FAIL overflow cyc%0d: got %s want %s", n, fmt(o), fmt(e)); end
            n++;
        end
    endtask

    task automatic test_bounce();
        obs_t e, o;
        int n = 0;
        cfg(32'd0, 32'd20, 32'd10, 16'd1, 2'd2);
        push_word(32'd0, 1);  push_word(32'd10, 1); push_word(32'd20, 1); push_word(32'd10, 1);
        push_word(32'd0, 1);  push_word(32'd10, 1); push_word(32'd20, 1);
        push(32'd20, 1'b0, 1'b0, 1'b0, 1'b0);
        push(32'd20, 1'b0, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            if (n == 7) abort = 1'b1;
            tick(); start = 1'b0; abort = 1'b0;
            e = exp_q.pop_front(); o = cur(); checks++;
            if (o !== e) begin errors++; $display("FAIL bounce cyc%0d: got %s want %s", n, fmt(o), fmt(e)); end
            n++;
        end
    endtask

    task automatic test_reject();
        obs_t e, o;
        int n = 0;
        cfg(32'd5, 32'd9, 32'd1, 16'd1, 2'd3);
        push(32'd20, 1'b0, 1'b0, 1'b1, 1'b1); push(32'd20, 1'b0, 1'b0, 1'b0, 1'b0);
        push(32'd20, 1'b0, 1'b0, 1'b1, 1'b1); push(32'd20, 1'b0, 1'b0, 1'b0, 1'b0);
        push_word(32'd7, 1);
        push(32'd7, 1'b0, 1'b0, 1'b1, 1'b0);  push(32'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            if (n == 2) cfg(32'd5, 32'd9, 32'd0, 16'd1, 2'd0);
            if (n == 4) cfg(32'd7, 32'd7, 32'd0, 16'd0, 2'd0);
            tick(); start = 1'b0;
            e = exp_q.pop_front(); o = cur(); checks++;
            if (o !== e) begin errors++; $display("FAIL reject cyc%0d: got %s want %s", n, fmt(o), fmt(e)); end
            n++;
        end
    endtask

    task automatic test_abort_repeat();
        obs_t e, o;
        int n = 0;
        cfg(32'd10, 32'd30, 32'd10, 16'd2, 2'd1);
        push_word(32'd10, 2); push_word(32'd20, 2); push_word(32'd30, 2); push_word(32'd10, 1);
        push(32'd10, 1'b0, 1'b0, 1'b0, 1'b0); push(32'd10, 1'b0, 1'b0, 1'b0, 1'b0);
        push_word(32'd500, 4);
        push(32'd500, 1'b0, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            if (n == 7) begin abort = 1'b1; cfg(32'd500, 32'd500, 32'd0, 16'd1, 2'd1); end
            if (n == 9)  cfg(32'd500, 32'd500, 32'd0, 16'd1, 2'd1);
            if (n == 11) cfg(32'd77, 32'd1, 32'd0, 16'd1, 2'd3);
            if (n == 13) abort = 1'b1;
            tick(); start = 1'b0; abort = 1'b0;
            e = exp_q.pop_front(); o = cur(); checks++;
            if (o !== e) begin errors++; $display("FAIL abort_repeat cyc%0d: got %s want %s", n, fmt(o), fmt(e)); end
            n++;
        end
    endtask

`ifdef PHASE_ALIGN_EN
    task automatic test_phase_align();
        obs_t e, o;
        int n = 0;
        cfg(32'd0, 32'd20, 32'd10, 16'd1, 2'd0);
        push_word(32'd0, 5); push_word(32'd10, 1);
        push(32'd10, 1'b0, 1'b0, 1'b0, 1'b0);
        while (exp_q.size() != 0) begin
            if (n == 5) acc_wrap = 1'b1;
            if (n == 6) abort = 1'b1;
            tick(); start = 1'b0; abort = 1'b0; acc_wrap = 1'b0;
            e = exp_q.pop_front(); o = cur(); checks++;
            if (o !== e) begin errors++; $display("FAIL phase_align cyc%0d: got %s want %s", n, fmt(o), fmt(e)); end
            n++;
        end
    endtask
`endif

    task automatic test_async_reset();
        obs_t e, o;
        cfg(32'd100, 32'd400, 32'd100, 16'd3, 2'd0);
        push_word(32'd100, 3); push_word(32'd200, 1);
        while (exp_q.size() != 0) begin
            tick(); start = 1'b0;
            e = exp_q.pop_front(); o = cur(); checks++;
            if (o !== e) begin errors++; $display("FAIL async_pre: got %s want %s", fmt(o), fmt(e)); end
        end
        #2 resetn = 1'b0;
        #1;
        o = cur(); checks++;
        if (o !== obs_t'(0)) begin errors++; $display("FAIL async_reset: got %s want all zero", fmt(o)); end
        tick();
        resetn = 1'b1;
        tick(); tick();
        o = cur(); checks++;
        if (o !== obs_t'(0)) begin errors++; $display("FAIL async_after: got %s want all zero", fmt(o)); end
    endtask

    initial begin
        test_reset();
        test_single_up();
        test_clamp_down();
        test_overflow();
        test_bounce();
        test_reject();
        test_abort_repeat();
`ifdef PHASE_ALIGN_EN
        test_phase_align();
`endif
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
